// File: rtl/rs_encoder.sv
// Systematic RS(6,2) encoder over GF(2^8) (poly 0x11D, alpha=2, t=2).
// Two message symbols are latched on a start pulse, clocked serially through a
// 4-stage parity LFSR, and the codeword w1..w6 is presented in decoder order:
// w1=d1, w2=d2, w3..w6 = parity x^3..x^0.

// One parity LFSR stage: nxt = prev ^ COEF*fb, with a constant GF(2^8) multiply.
module rs_parity_stage #(
  parameter logic [7:0] COEF = 8'd1
) (
  input  logic [7:0] prev,
  input  logic [7:0] fb,
  output logic [7:0] nxt
);

  // Shift-and-add multiply; each overflow out of bit 7 is folded back with 0x1D
  // (the low byte of 0x11D). COEF is constant, so this collapses to XOR gates.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'd0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // Stage output is purely combinational; the register lives in the top.
  always_comb nxt = prev ^ gf_mul(fb, COEF);

endmodule

module rs_encoder #(
  parameter logic [7:0] G3 = 8'd15,
  parameter logic [7:0] G2 = 8'd54,
  parameter logic [7:0] G1 = 8'd120,
  parameter logic [7:0] G0 = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  output logic       busy,
  output logic       ready,
  output logic [7:0] w1,
  output logic [7:0] w2,
  output logic [7:0] w3,
  output logic [7:0] w4,
  output logic [7:0] w5,
  output logic [7:0] w6
);

  localparam int NSTG = 4;
  localparam logic [NSTG-1:0][7:0] GEN = {G3, G2, G1, G0};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [1:0]             cnt;
  logic [7:0]             msg1, msg2;
  logic [NSTG-1:0][7:0]   r;      // r[3]=x^3 ... r[0]=x^0
  logic [NSTG-1:0][7:0]   r_nxt;
  logic [7:0]             m, fb;
  logic                   start;

  // d1 is fed on the first SHIFT cycle, d2 on the second.
  always_comb begin
    m     = (cnt == 2'd0) ? msg1 : msg2;
    fb    = m ^ r[NSTG-1];
    // A new encode may start from IDLE or straight out of DONE (back-to-back).
    start = signal && ((state == IDLE) || (state == DONE));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_stg
      if (gi == 0) begin : g_first
        rs_parity_stage #(.COEF(GEN[gi])) u_stg (
          .prev (8'd0),
          .fb   (fb),
          .nxt  (r_nxt[gi])
        );
      end else begin : g_rest
        rs_parity_stage #(.COEF(GEN[gi])) u_stg (
          .prev (r[gi-1]),
          .fb   (fb),
          .nxt  (r_nxt[gi])
        );
      end
    end
  endgenerate

  // Control FSM plus registered outputs. busy/ready/w are registered from the
  // current state, so they trail the state by one edge: ready shows the cycle
  // after DONE, which keeps back-to-back codewords exactly 3 cycles apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      msg1  <= 8'd0;
      msg2  <= 8'd0;
      r     <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      w1    <= 8'd0;
      w2    <= 8'd0;
      w3    <= 8'd0;
      w4    <= 8'd0;
      w5    <= 8'd0;
      w6    <= 8'd0;
    end else begin
      busy  <= (state == SHIFT);
      ready <= (state == DONE);
      if (state == DONE) begin
        w1 <= msg1;
        w2 <= msg2;
        w3 <= r[3];
        w4 <= r[2];
        w5 <= r[1];
        w6 <= r[0];
      end
      if (start) begin
        msg1  <= d1;
        msg2  <= d2;
        r     <= '0;
        cnt   <= 2'd0;
        state <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            r   <= r_nxt;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd1) state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
